// File: rtl/wdt_window.sv
// rtl/wdt_window.sv - windowed watchdog with prescaler, warning and saturating expiry count
module wdt_window #(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8,
    parameter int EXP_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wden,
    input  logic               wdlive,
    input  logic [CNT_W-1:0]   wtocnt,
    input  logic [CNT_W-1:0]   wwarncnt,
    input  logic [CNT_W-1:0]   wwincnt,
    input  logic [PRESC_W-1:0] presc,
    input  logic               win_mode,
    input  logic               cfg_load,
    output logic               wto,
    output logic               wwarn,
    output logic               early_kick,
    output logic [CNT_W-1:0]   cnt,
    output logic [EXP_W-1:0]   exp_cnt,
    output logic [1:0]         state
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_WARN    = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;

    localparam logic [CNT_W-1:0]   CNT_ZERO   = '0;
    localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
    localparam logic [PRESC_W-1:0] PRESC_ZERO = '0;
    localparam logic [PRESC_W-1:0] PRESC_ONE  = {{(PRESC_W-1){1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0]   EXP_ZERO   = '0;
    localparam logic [EXP_W-1:0]   EXP_ONE    = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0]   EXP_MAX    = '1;

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [PRESC_W-1:0] r_presc_cnt;
    logic [EXP_W-1:0]   r_exp_cnt;
    logic               r_wto;
    logic               r_wwarn;
    logic               r_early;

    logic [CNT_W-1:0]   r_sh_tocnt;
    logic [CNT_W-1:0]   r_sh_warncnt;
    logic [CNT_W-1:0]   r_sh_wincnt;
    logic [PRESC_W-1:0] r_sh_presc;
    logic               r_sh_win;

    logic [CNT_W-1:0]   r_act_tocnt;
    logic [CNT_W-1:0]   r_act_warncnt;
    logic [CNT_W-1:0]   r_act_wincnt;
    logic [PRESC_W-1:0] r_act_presc;
    logic               r_act_win;

    // Shadow values as they stand after this edge, so a coincident cfg_load is seen by a copy.
    logic [CNT_W-1:0]   w_sh_tocnt;
    logic [CNT_W-1:0]   w_sh_warncnt;
    logic [CNT_W-1:0]   w_sh_wincnt;
    logic [PRESC_W-1:0] w_sh_presc;
    logic               w_sh_win;

    logic               w_running;
    logic               w_tick;
    logic               w_cnt_sat;
    logic               w_expire;
    logic [CNT_W-1:0]   w_warn_m1;
    logic               w_warn_hit;
    logic               w_early;
    logic               w_copy;
    logic [EXP_W-1:0]   w_exp_inc;

    assign w_sh_tocnt   = cfg_load ? wtocnt   : r_sh_tocnt;
    assign w_sh_warncnt = cfg_load ? wwarncnt : r_sh_warncnt;
    assign w_sh_wincnt  = cfg_load ? wwincnt  : r_sh_wincnt;
    assign w_sh_presc   = cfg_load ? presc    : r_sh_presc;
    assign w_sh_win     = cfg_load ? win_mode : r_sh_win;

    assign w_running  = (r_state == S_RUN) || (r_state == S_WARN);
    assign w_tick     = w_running && (r_presc_cnt == r_act_presc);
    assign w_cnt_sat  = (r_cnt == CNT_MAX);
    assign w_expire   = w_tick && !w_cnt_sat && (r_cnt == r_act_tocnt);
    assign w_warn_m1  = r_act_warncnt - CNT_ONE;
    assign w_warn_hit = w_tick && (r_state == S_RUN) && (r_act_warncnt != CNT_ZERO)
                        && (r_cnt == w_warn_m1);
    assign w_early    = w_running && wdlive && r_act_win && (r_cnt < r_act_wincnt);
    assign w_exp_inc  = (r_exp_cnt == EXP_MAX) ? r_exp_cnt : (r_exp_cnt + EXP_ONE);

    assign w_copy = wden && (((r_state == S_IDLE) && 1'b1)
                             || (w_running && wdlive && !w_early)
                             || ((r_state == S_EXPIRED) && wdlive));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= CNT_ZERO;
            r_presc_cnt   <= PRESC_ZERO;
            r_exp_cnt     <= EXP_ZERO;
            r_wto         <= 1'b0;
            r_wwarn       <= 1'b0;
            r_early       <= 1'b0;
            r_sh_tocnt    <= CNT_ZERO;
            r_sh_warncnt  <= CNT_ZERO;
            r_sh_wincnt   <= CNT_ZERO;
            r_sh_presc    <= PRESC_ZERO;
            r_sh_win      <= 1'b0;
            r_act_tocnt   <= CNT_ZERO;
            r_act_warncnt <= CNT_ZERO;
            r_act_wincnt  <= CNT_ZERO;
            r_act_presc   <= PRESC_ZERO;
            r_act_win     <= 1'b0;
        end else begin
            r_early      <= 1'b0;
            r_sh_tocnt   <= w_sh_tocnt;
            r_sh_warncnt <= w_sh_warncnt;
            r_sh_wincnt  <= w_sh_wincnt;
            r_sh_presc   <= w_sh_presc;
            r_sh_win     <= w_sh_win;

            if (w_copy) begin
                r_act_tocnt   <= w_sh_tocnt;
                r_act_warncnt <= w_sh_warncnt;
                r_act_wincnt  <= w_sh_wincnt;
                r_act_presc   <= w_sh_presc;
                r_act_win     <= w_sh_win;
            end

            if (!wden) begin
                r_state     <= S_IDLE;
                r_cnt       <= CNT_ZERO;
                r_presc_cnt <= PRESC_ZERO;
                r_wto       <= 1'b0;
                r_wwarn     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state     <= S_RUN;
                        r_cnt       <= CNT_ZERO;
                        r_presc_cnt <= PRESC_ZERO;
                    end
                    S_RUN, S_WARN: begin
                        if (wdlive) begin
                            if (w_early) begin
                                // Early kick holds cnt so software can see where the window was violated.
                                r_state   <= S_EXPIRED;
                                r_wto     <= 1'b1;
                                r_wwarn   <= 1'b0;
                                r_early   <= 1'b1;
                                r_exp_cnt <= w_exp_inc;
                            end else begin
                                r_state     <= S_RUN;
                                r_cnt       <= CNT_ZERO;
                                r_presc_cnt <= PRESC_ZERO;
                                r_wwarn     <= 1'b0;
                            end
                        end else begin
                            r_presc_cnt <= w_tick ? PRESC_ZERO : (r_presc_cnt + PRESC_ONE);
                            if (w_expire) begin
                                r_state   <= S_EXPIRED;
                                r_cnt     <= r_cnt + CNT_ONE;
                                r_wto     <= 1'b1;
                                r_wwarn   <= 1'b0;
                                r_exp_cnt <= w_exp_inc;
                            end else begin
                                if (w_tick && !w_cnt_sat) begin
                                    r_cnt <= r_cnt + CNT_ONE;
                                end
                                if (w_warn_hit) begin
                                    r_state <= S_WARN;
                                    r_wwarn <= 1'b1;
                                end
                            end
                        end
                    end
                    S_EXPIRED: begin
                        if (wdlive) begin
                            r_state     <= S_RUN;
                            r_cnt       <= CNT_ZERO;
                            r_presc_cnt <= PRESC_ZERO;
                            r_wto       <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign wto        = r_wto;
    assign wwarn      = r_wwarn;
    assign early_kick = r_early;
    assign cnt        = r_cnt;
    assign exp_cnt    = r_exp_cnt;
    assign state      = r_state;

endmodule

// File: tb/tb_wdt_window.sv
// tb/tb_wdt_window.sv - directed and randomized self-checking bench for wdt_window
module tb_wdt_window;

    logic        clk;
    logic        rst;
    logic        wden;
    logic        wdlive;
    logic [31:0] wtocnt;
    logic [31:0] wwarncnt;
    logic [31:0] wwincnt;
    logic [7:0]  presc;
    logic        win_mode;
    logic        cfg_load;
    logic        wto;
    logic        wwarn;
    logic        early_kick;
    logic [31:0] cnt;
    logic [3:0]  exp_cnt;
    logic [1:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: elapsed cycles since the last (re)start; count = elapsed / (presc+1).
    int     m_mode = 0;      // 0 idle, 1 counting, 2 expired
    longint m_t = 0;
    longint m_hold = 0;
    int     m_exp = 0;
    bit     m_wto = 0;
    bit     m_wwarn = 0;
    bit     m_early = 0;
    longint sh_to = 0, sh_wa = 0, sh_wi = 0, sh_p = 0;
    bit     sh_w = 0;
    longint a_to = 0, a_wa = 0, a_wi = 0, a_p = 0;
    bit     a_w = 0;

    wdt_window dut (
        .clk       (clk),
        .rst       (rst),
        .wden      (wden),
        .wdlive    (wdlive),
        .wtocnt    (wtocnt),
        .wwarncnt  (wwarncnt),
        .wwincnt   (wwincnt),
        .presc     (presc),
        .win_mode  (win_mode),
        .cfg_load  (cfg_load),
        .wto       (wto),
        .wwarn     (wwarn),
        .early_kick(early_kick),
        .cnt       (cnt),
        .exp_cnt   (exp_cnt),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint m_cnt();
        if (m_mode == 1) return m_t / (a_p + 1);
        if (m_mode == 2) return m_hold;
        return 0;
    endfunction

    function automatic longint m_state();
        if (m_mode == 1) return m_wwarn ? 2 : 1;
        if (m_mode == 2) return 3;
        return 0;
    endfunction

    task automatic copy_active();
        a_to = sh_to; a_wa = sh_wa; a_wi = sh_wi; a_p = sh_p; a_w = sh_w;
    endtask

    task automatic bump_exp();
        if (m_exp < 15) m_exp = m_exp + 1;
    endtask

    task automatic model_edge();
        longint cur;
        longint nc;
        if (rst) begin
            m_mode = 0; m_t = 0; m_hold = 0; m_exp = 0;
            m_wto = 0; m_wwarn = 0; m_early = 0;
            sh_to = 0; sh_wa = 0; sh_wi = 0; sh_p = 0; sh_w = 0;
            copy_active();
        end else begin
            cur = m_cnt();
            m_early = 0;
            if (cfg_load) begin
                sh_to = longint'(wtocnt); sh_wa = longint'(wwarncnt);
                sh_wi = longint'(wwincnt); sh_p = longint'(presc); sh_w = win_mode;
            end
            if (!wden) begin
                m_mode = 0; m_t = 0; m_wto = 0; m_wwarn = 0;
            end else if (m_mode == 0) begin
                m_mode = 1; m_t = 0; copy_active();
            end else if (m_mode == 2) begin
                if (wdlive) begin
                    m_mode = 1; m_t = 0; m_wto = 0; copy_active();
                end
            end else if (wdlive) begin
                if (a_w && cur < a_wi) begin
                    m_mode = 2; m_hold = cur; m_wto = 1; m_wwarn = 0; m_early = 1; bump_exp();
                end else begin
                    m_t = 0; m_wwarn = 0; copy_active();
                end
            end else begin
                m_t = m_t + 1;
                nc = m_t / (a_p + 1);
                if (nc > a_to) begin
                    m_mode = 2; m_hold = nc; m_wto = 1; m_wwarn = 0; bump_exp();
                end else if (a_wa != 0 && nc >= a_wa) begin
                    m_wwarn = 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input longint expv);
        n_checks++;
        assert (obs === 64'(expv)) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("model_state", 64'(state), m_state());
        chk("model_cnt", 64'(cnt), m_cnt());
        chk("model_wto", 64'(wto), longint'(m_wto));
        chk("model_wwarn", 64'(wwarn), longint'(m_wwarn));
        chk("model_early", 64'(early_kick), longint'(m_early));
        chk("model_exp", 64'(exp_cnt), longint'(m_exp));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_cfg(input int to, input int wa, input int wi, input int p, input bit w);
        wtocnt = 32'(to); wwarncnt = 32'(wa); wwincnt = 32'(wi); presc = 8'(p); win_mode = w;
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wden = 1'b0; wdlive = 1'b0; cfg_load = 1'b0;
        wtocnt = '0; wwarncnt = '0; wwincnt = '0; presc = '0; win_mode = 1'b0;

        step();
        rst = 1'b0;
        chk("reset_state", 64'(state), 0);
        chk("reset_cnt", 64'(cnt), 0);
        chk("reset_flags", 64'({wto, wwarn, early_kick}), 0);
        chk("reset_exp", 64'(exp_cnt), 0);

        // Basic timeout
        set_cfg(5, 0, 0, 0, 0);
        wden = 1'b1;
        step();
        repeat (5) step();
        chk("basic_no_wto_e5", 64'(wto), 0);
        step();
        chk("basic_wto_e6", 64'(wto), 1);
        chk("basic_cnt_e6", 64'(cnt), 6);
        chk("basic_exp_e6", 64'(exp_cnt), 1);
        chk("basic_wwarn", 64'(wwarn), 0);

        // Warning then kick
        wden = 1'b0;
        set_cfg(10, 7, 0, 0, 0);
        wden = 1'b1;
        step();
        repeat (7) step();
        chk("warn_e7", 64'(wwarn), 1);
        chk("warn_state", 64'(state), 2);
        wdlive = 1'b1;
        step();
        wdlive = 1'b0;
        chk("kick_cnt", 64'(cnt), 0);
        chk("kick_wwarn", 64'(wwarn), 0);
        chk("kick_state", 64'(state), 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("kick_no_wto", 64'(wto), 0);
        end

        // Prescaler
        wden = 1'b0;
        set_cfg(2, 0, 0, 3, 0);
        wden = 1'b1;
        step();
        repeat (3) step();
        chk("presc_cnt_e3", 64'(cnt), 0);
        step();
        chk("presc_cnt_e4", 64'(cnt), 1);
        repeat (7) step();
        chk("presc_no_wto_e11", 64'(wto), 0);
        step();
        chk("presc_wto_e12", 64'(wto), 1);
        chk("presc_state_e12", 64'(state), 3);

        // Window violation, then a legal kick
        wden = 1'b0;
        set_cfg(20, 0, 4, 0, 1);
        wden = 1'b1;
        step();
        repeat (2) step();
        wdlive = 1'b1;
        step();
        wdlive = 1'b0;
        chk("early_pulse", 64'(early_kick), 1);
        chk("early_state", 64'(state), 3);
        chk("early_wto", 64'(wto), 1);
        step();
        chk("early_pulse_end", 64'(early_kick), 0);
        wden = 1'b0;
        step();
        wden = 1'b1;
        step();
        repeat (5) step();
        wdlive = 1'b1;
        step();
        wdlive = 1'b0;
        chk("win_ok_cnt", 64'(cnt), 0);
        chk("win_ok_flags", 64'({wto, early_kick}), 0);
        chk("win_ok_state", 64'(state), 1);

        // Kick on the expiry tick
        wden = 1'b0;
        set_cfg(3, 0, 0, 0, 0);
        wden = 1'b1;
        step();
        repeat (3) step();
        wdlive = 1'b1;
        step();
        wdlive = 1'b0;
        chk("kick_at_expiry_cnt", 64'(cnt), 0);
        chk("kick_at_expiry_state", 64'(state), 1);
        chk("kick_at_expiry_wto", 64'(wto), 0);

        // wden=0 beats wdlive
        wden = 1'b0; wdlive = 1'b1;
        step();
        wdlive = 1'b0;
        chk("disable_over_kick", 64'(state), 0);

        // Repeated expiry / recovery until exp_cnt saturates
        set_cfg(0, 0, 0, 0, 0);
        wden = 1'b1;
        step();
        for (int i = 0; i < 18; i++) begin
            step();
            chk("sat_expired", 64'(state), 3);
            wdlive = 1'b1;
            step();
            wdlive = 1'b0;
            chk("sat_recover_wto", 64'(wto), 0);
            chk("sat_recover_state", 64'(state), 1);
        end
        chk("exp_saturated", 64'(exp_cnt), 15);

        // Reset while warning
        wden = 1'b0;
        set_cfg(10, 3, 0, 0, 0);
        wden = 1'b1;
        step();
        repeat (3) step();
        chk("pre_rst_warn", 64'(state), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_warn_state", 64'(state), 0);
        chk("rst_warn_cnt", 64'(cnt), 0);
        chk("rst_warn_flags", 64'({wto, wwarn, early_kick}), 0);
        chk("rst_warn_exp", 64'(exp_cnt), 0);

        // cfg_load while running takes effect only at the next kick
        wden = 1'b0;
        set_cfg(10, 0, 0, 0, 0);
        wden = 1'b1;
        step();
        repeat (2) step();
        wtocnt = 32'd3; cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        repeat (2) step();
        chk("late_cfg_cnt", 64'(cnt), 5);
        chk("late_cfg_no_wto", 64'(wto), 0);
        wdlive = 1'b1;
        step();
        wdlive = 1'b0;
        repeat (3) step();
        chk("late_cfg_e3", 64'(wto), 0);
        step();
        chk("late_cfg_e4", 64'(wto), 1);

        // Randomized traffic against the model
        wden = 1'b0;
        step();
        for (int i = 0; i < 800; i++) begin
            rst      = ($urandom % 100) == 0;
            wden     = ($urandom % 20) != 0;
            wdlive   = ($urandom % 6) == 0;
            cfg_load = ($urandom % 8) == 0;
            wtocnt   = 32'($urandom % 13);
            wwarncnt = 32'($urandom % 15);
            wwincnt  = 32'($urandom % 9);
            presc    = 8'($urandom % 4);
            win_mode = 1'($urandom % 2);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
